// File: rtl/tc_controller.sv
// tc_controller
// Hit/miss and refill sequencer for a direct-mapped texture cache
// (32 lines x 16 words) backed by a 512 x 32-bit data RAM.
// Holds the tag/valid array, answers one-word texel reads, fetches the
// whole line from memory on a miss, writes it into the RAM beat by beat,
// then replays the original read.
//
// Ports:
//   core_clock_i, core_reset_n_i      clock, async active-low reset
//   tc_req_valid_i/ready_o/addr_i     texel read request (byte address)
//   tc_rsp_valid_o/data_o             one-cycle read response strobe + word
//   tc_inv_i                          invalidate-all pulse
//   mem_req_valid_o/ready_i/addr_o    line fetch request (line aligned)
//   mem_rsp_valid_i/data_i            fill beats, ascending word order
//   bram_rd_addr_o/rd_data_i          data RAM read port (1-cycle latency)
//   bram_wr_en_o/wr_addr_o/wr_data_o  data RAM byte-enable write port
//   hit_count_o, miss_count_o         saturating performance counters
module tc_controller #(
  parameter int CNT_W = 16
) (
  input  logic             core_clock_i,
  input  logic             core_reset_n_i,
  input  logic             tc_req_valid_i,
  output logic             tc_req_ready_o,
  input  logic [31:0]      tc_req_addr_i,
  output logic             tc_rsp_valid_o,
  output logic [31:0]      tc_rsp_data_o,
  input  logic             tc_inv_i,
  output logic             mem_req_valid_o,
  input  logic             mem_req_ready_i,
  output logic [31:0]      mem_req_addr_o,
  input  logic             mem_rsp_valid_i,
  input  logic [31:0]      mem_rsp_data_i,
  output logic [8:0]       bram_rd_addr_o,
  input  logic [31:0]      bram_rd_data_i,
  output logic [3:0]       bram_wr_en_o,
  output logic [8:0]       bram_wr_addr_o,
  output logic [31:0]      bram_wr_data_o,
  output logic [CNT_W-1:0] hit_count_o,
  output logic [CNT_W-1:0] miss_count_o
);

  typedef enum logic [1:0] {IDLE, MISS_REQ, FILL, REPLAY} state_t;

  state_t           state_q, state_d;
  logic [31:0]      valid_q;
  logic [20:0]      tag_q [32];
  logic [20:0]      lat_tag_q;
  logic [4:0]       lat_index_q;
  logic [3:0]       lat_word_q;
  logic [3:0]       beat_q;
  logic             kill_q;
  logic             rsp_vld_p1;
  logic [CNT_W-1:0] hit_q, miss_q;

  logic [20:0] req_tag;
  logic [4:0]  req_index;
  logic [3:0]  req_word;
  logic        accept, hit, fill_beat, fill_done;
  logic        unused_addr_bits;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign req_tag   = tc_req_addr_i[31:11];
  assign req_index = tc_req_addr_i[10:6];
  assign req_word  = tc_req_addr_i[5:2];
  assign unused_addr_bits = ^tc_req_addr_i[1:0];

  assign accept    = tc_req_valid_i && (state_q == IDLE);
  assign hit       = valid_q[req_index] && (tag_q[req_index] == req_tag);
  assign fill_beat = (state_q == FILL) && mem_rsp_valid_i;
  assign fill_done = fill_beat && (beat_q == 4'd15);

  // Stage p0: combinational request decode, RAM port steering, next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (accept && !hit) state_d = MISS_REQ;
      MISS_REQ: if (mem_req_ready_i) state_d = FILL;
      FILL:     if (fill_done) state_d = REPLAY;
      REPLAY:   state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  assign tc_req_ready_o  = (state_q == IDLE);
  assign bram_rd_addr_o  = (state_q == IDLE) ? {req_index, req_word}
                                             : {lat_index_q, lat_word_q};
  assign bram_wr_en_o    = fill_beat ? 4'hF : 4'h0;
  assign bram_wr_addr_o  = {lat_index_q, beat_q};
  assign bram_wr_data_o  = mem_rsp_data_i;
  assign mem_req_valid_o = (state_q == MISS_REQ);
  assign mem_req_addr_o  = {lat_tag_q, lat_index_q, 6'b0};
  assign tc_rsp_valid_o  = rsp_vld_p1;
  assign tc_rsp_data_o   = bram_rd_data_i;
  assign hit_count_o     = hit_q;
  assign miss_count_o    = miss_q;

  // Stage p1: control state, response strobe aligned with RAM read data
  always_ff @(posedge core_clock_i or negedge core_reset_n_i) begin
    if (!core_reset_n_i) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      beat_q     <= '0;
      kill_q     <= 1'b0;
      rsp_vld_p1 <= 1'b0;
      hit_q      <= '0;
      miss_q     <= '0;
    end else begin
      state_q    <= state_d;
      rsp_vld_p1 <= (accept && hit) || (state_q == REPLAY);

      if (accept && hit)  hit_q  <= sat_inc(hit_q);
      if (accept && !hit) miss_q <= sat_inc(miss_q);

      if ((state_q == MISS_REQ) && mem_req_ready_i) beat_q <= '0;
      else if (fill_beat)                           beat_q <= beat_q + 4'd1;

      // An invalidate racing a fill must not let that fill mark its line valid.
      if (state_q == REPLAY)
        kill_q <= 1'b0;
      else if (tc_inv_i && ((state_q == MISS_REQ) || (state_q == FILL)))
        kill_q <= 1'b1;

      // Invalidate wins over a fill completing on the same edge.
      if (tc_inv_i)
        valid_q <= '0;
      else if (fill_done && !kill_q)
        valid_q[lat_index_q] <= 1'b1;
    end
  end

  always_ff @(posedge core_clock_i) begin
    if (accept && !hit) begin
      lat_tag_q   <= req_tag;
      lat_index_q <= req_index;
      lat_word_q  <= req_word;
    end
    if (fill_done) tag_q[lat_index_q] <= lat_tag_q;
  end

endmodule

// File: tb/tb_tc_controller.sv
// Directed testbench for tc_controller: behavioural data RAM, scripted
// memory responder, and a second CNT_W=4 instance sharing all inputs.
module tb_tc_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        inv;
  logic        mem_req_ready;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic [31:0] rd_data;

  logic        req_ready, rsp_valid, mem_req_valid;
  logic [31:0] rsp_data, mem_req_addr, wr_data;
  logic [8:0]  rd_addr, wr_addr;
  logic [3:0]  wr_en;
  logic [15:0] hit_cnt, miss_cnt;

  logic        d4_req_ready, d4_rsp_valid, d4_mem_req_valid;
  logic [31:0] d4_rsp_data, d4_mem_req_addr, d4_wr_data;
  logic [8:0]  d4_rd_addr, d4_wr_addr;
  logic [3:0]  d4_wr_en;
  logic [3:0]  d4_hit_cnt, d4_miss_cnt;

  logic [31:0] ram [512];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tc_controller #(.CNT_W(16)) u_dut (
    .core_clock_i(clk), .core_reset_n_i(rst_n),
    .tc_req_valid_i(req_valid), .tc_req_ready_o(req_ready), .tc_req_addr_i(req_addr),
    .tc_rsp_valid_o(rsp_valid), .tc_rsp_data_o(rsp_data), .tc_inv_i(inv),
    .mem_req_valid_o(mem_req_valid), .mem_req_ready_i(mem_req_ready), .mem_req_addr_o(mem_req_addr),
    .mem_rsp_valid_i(mem_rsp_valid), .mem_rsp_data_i(mem_rsp_data),
    .bram_rd_addr_o(rd_addr), .bram_rd_data_i(rd_data),
    .bram_wr_en_o(wr_en), .bram_wr_addr_o(wr_addr), .bram_wr_data_o(wr_data),
    .hit_count_o(hit_cnt), .miss_count_o(miss_cnt)
  );

  tc_controller #(.CNT_W(4)) u_dut4 (
    .core_clock_i(clk), .core_reset_n_i(rst_n),
    .tc_req_valid_i(req_valid), .tc_req_ready_o(d4_req_ready), .tc_req_addr_i(req_addr),
    .tc_rsp_valid_o(d4_rsp_valid), .tc_rsp_data_o(d4_rsp_data), .tc_inv_i(inv),
    .mem_req_valid_o(d4_mem_req_valid), .mem_req_ready_i(mem_req_ready), .mem_req_addr_o(d4_mem_req_addr),
    .mem_rsp_valid_i(mem_rsp_valid), .mem_rsp_data_i(mem_rsp_data),
    .bram_rd_addr_o(d4_rd_addr), .bram_rd_data_i(rd_data),
    .bram_wr_en_o(d4_wr_en), .bram_wr_addr_o(d4_wr_addr), .bram_wr_data_o(d4_wr_data),
    .hit_count_o(d4_hit_cnt), .miss_count_o(d4_miss_cnt)
  );

  // Data RAM model: byte-enable writes, registered read.
  always @(posedge clk) begin
    if (wr_en[0]) ram[wr_addr][7:0]   <= wr_data[7:0];
    if (wr_en[1]) ram[wr_addr][15:8]  <= wr_data[15:8];
    if (wr_en[2]) ram[wr_addr][23:16] <= wr_data[23:16];
    if (wr_en[3]) ram[wr_addr][31:24] <= wr_data[31:24];
    rd_data <= ram[rd_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; inv = 1'b0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    #3;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0h want 1", req_ready); end
    checks++; if ({mem_req_valid, rsp_valid, wr_en} !== 6'b0) begin errors++; $display("FAIL reset_ctrl got %0h want 0", {mem_req_valid, rsp_valid, wr_en}); end
    checks++; if ({hit_cnt, miss_cnt} !== 32'h0) begin errors++; $display("FAIL reset_counts got %0h want 0", {hit_cnt, miss_cnt}); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Runs one full miss starting in the current cycle; ends in the response cycle.
  task automatic run_miss(input logic [31:0] addr, input logic [31:0] base,
                          input int stall, input bit gaps, input int inv_beat);
    logic [31:0] line, exp_d;
    logic [8:0]  exp_a;
    int beat, budget;
    line = {addr[31:6], 6'b0};
    req_valid = 1'b1; req_addr = addr;
    settle();
    checks++; if (req_ready !== 1'b1 || rd_addr !== addr[10:2]) begin errors++; $display("FAIL miss_accept got rdy=%0h ra=%0h want rdy=1 ra=%0h", req_ready, rd_addr, addr[10:2]); end
    tick();
    req_valid = 1'b0; req_addr = '0;
    for (int i = 0; i < stall; i++) begin
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 32'hDEAD0000 + i;
      settle();
      checks++; if ({mem_req_valid, mem_req_addr} !== {1'b1, line}) begin errors++; $display("FAIL stall_req got v=%0h a=%0h want v=1 a=%0h", mem_req_valid, mem_req_addr, line); end
      checks++; if ({wr_en, req_ready} !== 5'b0) begin errors++; $display("FAIL stall_quiet got we=%0h rdy=%0h want 0", wr_en, req_ready); end
      tick();
    end
    mem_req_ready = 1'b1; mem_rsp_valid = 1'b0;
    settle();
    checks++; if ({mem_req_valid, mem_req_addr} !== {1'b1, line}) begin errors++; $display("FAIL miss_req got v=%0h a=%0h want v=1 a=%0h", mem_req_valid, mem_req_addr, line); end
    tick();
    mem_req_ready = 1'b0;
    beat = 0; budget = 0;
    while (beat < 16 && budget < 200) begin
      budget++;
      if (gaps && $urandom_range(0, 2) == 0) begin
        mem_rsp_valid = 1'b0; inv = 1'b0;
        settle();
        checks++; if ({wr_en, req_ready} !== 5'b0) begin errors++; $display("FAIL gap_quiet got we=%0h rdy=%0h want 0", wr_en, req_ready); end
      end else begin
        exp_d = base + 32'(beat);
        exp_a = {addr[10:6], 4'(beat)};
        mem_rsp_valid = 1'b1; mem_rsp_data = exp_d; inv = (beat == inv_beat);
        settle();
        checks++; if ({wr_en, wr_addr, wr_data} !== {4'hF, exp_a, exp_d}) begin errors++; $display("FAIL fill_write beat %0d got we=%0h wa=%0h wd=%0h want F %0h %0h", beat, wr_en, wr_addr, wr_data, exp_a, exp_d); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL fill_ready got %0h want 0", req_ready); end
        beat++;
      end
      tick();
    end
    inv = 1'b0;
    if (beat < 16) begin checks++; errors++; $display("FAIL fill_timeout got %0d beats want 16", beat); end
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'hBAD0BAD0;
    settle();
    checks++; if ({wr_en, rsp_valid, rd_addr} !== {5'b0, addr[10:2]}) begin errors++; $display("FAIL replay got we=%0h rv=%0h ra=%0h want 0 0 %0h", wr_en, rsp_valid, rd_addr, addr[10:2]); end
    tick();
    mem_rsp_valid = 1'b0;
    settle();
    exp_d = base + 32'(addr[5:2]);
    checks++; if ({rsp_valid, rsp_data} !== {1'b1, exp_d}) begin errors++; $display("FAIL miss_rsp got v=%0h d=%0h want 1 %0h", rsp_valid, rsp_data, exp_d); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL miss_done_ready got %0h want 1", req_ready); end
  endtask

  task automatic do_hit(input logic [31:0] addr, input logic [31:0] exp);
    req_valid = 1'b1; req_addr = addr;
    settle();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL hit_ready got %0h want 1", req_ready); end
    tick();
    req_valid = 1'b0;
    settle();
    checks++; if ({rsp_valid, rsp_data, mem_req_valid} !== {1'b1, exp, 1'b0}) begin errors++; $display("FAIL hit_rsp %0h got v=%0h d=%0h mr=%0h want 1 %0h 0", addr, rsp_valid, rsp_data, mem_req_valid, exp); end
  endtask

  task automatic test_miss_basic();
    run_miss(32'h40, 32'h100, 0, 1'b0, -1);
    checks++; if ({hit_cnt, miss_cnt} !== {16'd0, 16'd1}) begin errors++; $display("FAIL basic_counts got %0h want 00000001", {hit_cnt, miss_cnt}); end
  endtask

  task automatic test_back_to_back();
    req_valid = 1'b1; req_addr = 32'h4C;
    settle();
    tick();
    req_addr = 32'h7C;
    settle();
    checks++; if ({rsp_valid, rsp_data} !== {1'b1, 32'h103}) begin errors++; $display("FAIL b2b_first got v=%0h d=%0h want 1 103", rsp_valid, rsp_data); end
    tick();
    req_valid = 1'b0;
    settle();
    checks++; if ({rsp_valid, rsp_data} !== {1'b1, 32'h10F}) begin errors++; $display("FAIL b2b_second got v=%0h d=%0h want 1 10f", rsp_valid, rsp_data); end
    checks++; if ({hit_cnt, miss_cnt} !== {16'd2, 16'd1}) begin errors++; $display("FAIL b2b_counts got %0h want 00020001", {hit_cnt, miss_cnt}); end
    tick();
    settle();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rsp_one_cycle got %0h want 0", rsp_valid); end
  endtask

  task automatic test_conflict();
    run_miss(32'h840, 32'h200, 0, 1'b0, -1);
    run_miss(32'h40, 32'h100, 0, 1'b0, -1);
    checks++; if (miss_cnt !== 16'd3) begin errors++; $display("FAIL conflict_misses got %0d want 3", miss_cnt); end
  endtask

  task automatic test_stall();
    run_miss(32'h108C, 32'h300, 5, 1'b1, -1);
    do_hit(32'h1080, 32'h300);
    checks++; if ({hit_cnt, miss_cnt} !== {16'd3, 16'd4}) begin errors++; $display("FAIL stall_counts got %0h want 00030004", {hit_cnt, miss_cnt}); end
  endtask

  task automatic test_inv_idle();
    req_valid = 1'b1; req_addr = 32'h44; inv = 1'b1;
    settle();
    tick();
    req_valid = 1'b0; inv = 1'b0;
    settle();
    checks++; if ({rsp_valid, rsp_data} !== {1'b1, 32'h101}) begin errors++; $display("FAIL inv_hit got v=%0h d=%0h want 1 101", rsp_valid, rsp_data); end
    checks++; if (hit_cnt !== 16'd4) begin errors++; $display("FAIL inv_hit_count got %0d want 4", hit_cnt); end
    run_miss(32'h40, 32'h100, 0, 1'b0, -1);
    tick();
    inv = 1'b1;
    tick();
    inv = 1'b0;
    run_miss(32'h40, 32'h100, 0, 1'b0, -1);
    checks++; if (miss_cnt !== 16'd6) begin errors++; $display("FAIL inv_idle_misses got %0d want 6", miss_cnt); end
  endtask

  task automatic test_inv_fill();
    run_miss(32'hC8, 32'h400, 0, 1'b0, 5);
    run_miss(32'hC0, 32'h500, 0, 1'b0, -1);
    do_hit(32'hC4, 32'h501);
    checks++; if ({hit_cnt, miss_cnt} !== {16'd5, 16'd8}) begin errors++; $display("FAIL inv_fill_counts got %0h want 00050008", {hit_cnt, miss_cnt}); end
  endtask

  task automatic test_reset_mid_fill();
    req_valid = 1'b1; req_addr = 32'h100;
    settle();
    tick();
    req_valid = 1'b0; mem_req_ready = 1'b1;
    settle();
    tick();
    mem_req_ready = 1'b0;
    for (int b = 0; b < 7; b++) begin
      mem_rsp_valid = 1'b1; mem_rsp_data = 32'h700 + b;
      tick();
    end
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h707;
    settle();
    checks++; if ({wr_en, wr_addr} !== {4'hF, 9'h047}) begin errors++; $display("FAIL beat7_write got we=%0h wa=%0h want F 47", wr_en, wr_addr); end
    rst_n = 1'b0;
    #1;
    checks++; if ({req_ready, mem_req_valid, rsp_valid, wr_en} !== 7'b1000000) begin errors++; $display("FAIL async_reset got %0h want 40", {req_ready, mem_req_valid, rsp_valid, wr_en}); end
    checks++; if ({hit_cnt, miss_cnt, d4_hit_cnt, d4_miss_cnt} !== 40'h0) begin errors++; $display("FAIL reset_counters got %0h want 0", {hit_cnt, miss_cnt, d4_hit_cnt, d4_miss_cnt}); end
    mem_rsp_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    run_miss(32'h100, 32'h600, 0, 1'b0, -1);
    checks++; if ({hit_cnt, miss_cnt} !== {16'd0, 16'd1}) begin errors++; $display("FAIL post_reset_counts got %0h want 00000001", {hit_cnt, miss_cnt}); end
  endtask

  task automatic test_saturation();
    logic [31:0] exp;
    for (int k = 0; k < 20; k++) begin
      req_valid = 1'b1; req_addr = 32'h100 + 32'(4 * (k % 16));
      settle();
      if (k > 0) begin
        exp = 32'h600 + 32'((k - 1) % 16);
        checks++; if ({rsp_valid, rsp_data} !== {1'b1, exp}) begin errors++; $display("FAIL sat_hit %0d got v=%0h d=%0h want 1 %0h", k, rsp_valid, rsp_data, exp); end
      end
      tick();
    end
    req_valid = 1'b0;
    settle();
    checks++; if ({hit_cnt, d4_hit_cnt} !== {16'd20, 4'hF}) begin errors++; $display("FAIL hit_saturate got %0h/%0h want 14/f", hit_cnt, d4_hit_cnt); end
    for (int k = 1; k <= 16; k++) begin
      run_miss({21'(k), 5'd5, 6'd0}, 32'(k) << 8, 0, 1'b0, -1);
    end
    checks++; if ({miss_cnt, d4_miss_cnt} !== {16'd17, 4'hF}) begin errors++; $display("FAIL miss_saturate got %0h/%0h want 11/f", miss_cnt, d4_miss_cnt); end
    checks++; if (d4_hit_cnt !== 4'hF) begin errors++; $display("FAIL hit_stays_sat got %0h want f", d4_hit_cnt); end
  endtask

  initial begin
    test_reset();
    test_miss_basic();
    test_back_to_back();
    test_conflict();
    test_stall();
    test_inv_idle();
    test_inv_fill();
    test_reset_mid_fill();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
